axi4lite_master_mipi: RTL and testbench
=======================================

Name: axi4lite_master_mipi

Overview:
- AXI4-Lite initiator that turns single-beat register commands from a local sequencer into AXI4-Lite read or write transactions.
- Typical sequencer: a sensor/MIPI configuration engine.
- Counterpart to the team's AXI4-Lite slave memory adapters; drives their aw/w/b/ar/r channels.
- One outstanding transaction at a time. The completion status and read data are returned on a response port.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, awaddr, araddr.
- DATA_WIDTH, 32, width of data paths. Strobe width is DATA_WIDTH/8.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  completion available
- rsp_ready  in  1  completion consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  captured bresp/rresp
- awvalid  out  1; awready  in  1; awaddr  out  ADDR_WIDTH; awprot  out  3
- wvalid  out  1; wready  in  1; wdata  out  DATA_WIDTH; wstrb  out  DATA_WIDTH/8
- bvalid  in  1; bready  out  1; bresp  in  2
- arvalid  out  1; arready  in  1; araddr  out  ADDR_WIDTH; arprot  out  3
- rvalid  in  1; rready  out  1; rdata  in  DATA_WIDTH; rresp  in  2

Behaviour:
- One clock, aclk. Reset aresetn is asynchronous, active-low.
- Reset values, all 0: every valid/ready output, all address/data/strobe outputs, rsp_rdata, rsp_resp, and the FSM (IDLE).
- cmd_ready is a registered output. It is 0 during reset and rises on the first clock after reset release.
- awprot and arprot are tied to 3'b000.
- All outputs except the tied prot signals are registered.

FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture addr/wdata/wstrb into the AXI output registers and drop cmd_ready.
  - If cmd_write=1, go to WR with awvalid=1 and wvalid=1 on the next cycle.
  - If cmd_write=0, go to RD_ADDR with arvalid=1.
- WR:
  - awvalid and wvalid each drop independently on their own handshake.
  - Track completion with two flags.
  - When both handshakes are complete (same cycle or different cycles), go to WR_RESP with bready=1.
  - Handle the case where wready arrives only after the aw handshake.
- WR_RESP: on bvalid&&bready, capture bresp into rsp_resp, set rsp_rdata=0, bready=0, go to RSP.
- RD_ADDR: on arvalid&&arready, arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid&&rready, capture rdata into rsp_rdata and rresp into rsp_resp, rready=0, go to RSP.
- RSP:
  - rsp_valid=1 and held, with data stable, until rsp_ready.
  - On handshake: rsp_valid=0, cmd_ready=1, go to IDLE.

Rules and timing:
- AXI valids are never withdrawn before their handshake. Address, data and strobe stay stable while valid is high.
- Commands are not accepted outside IDLE. cmd_valid in other states is ignored.
- Non-OKAY responses (SLVERR/DECERR) are passed through unmodified. No retry.
- Latency against an always-ready slave (awready=wready=arready=1, bvalid/rvalid one cycle after handshake):
  - Write: command accepted in cycle 0, rsp_valid in cycle 4.
  - Read: command accepted in cycle 0, rsp_valid in cycle 4.
- Reset asserted mid-transaction: all outputs drop to 0 asynchronously and the command is dropped. Late bvalid/rvalid after reset release are ignored in IDLE.
- No timeout. A hung slave stalls the block indefinitely.

Test Plan:
- Write, zero-wait slave:
  - Stimulus: cmd addr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 0xF.
  - Required: awaddr=0x10, wdata=0xDEADBEEF on the bus; one bready beat; rsp_valid in cycle 4; rsp_resp=0, rsp_rdata=0.
- Read, slave with rdata 0x1234_5678 delayed 5 cycles:
  - Stimulus: read cmd to addr 0x24.
  - Required: arvalid high until arready; rready held until rvalid; rsp_rdata=0x12345678.
- Write, wready 3 cycles after awready:
  - Required: awvalid drops after the aw handshake; wvalid stays high until wready; exactly one aw beat and one w beat.
- Response backpressure, rsp_ready low 4 cycles:
  - Required: rsp_valid and data stable; cmd_ready=0 throughout.
  - Second cmd_valid is not accepted until the cycle after the rsp handshake.
- Error response:
  - Stimulus: slave returns rresp=2'b10.
  - Required: rsp_resp=2'b10; block returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert aresetn low while wvalid is pending.
  - Required: all outputs 0 immediately. After release, cmd_ready=1 on the next clock and a new read completes normally.

Source files
------------

// File: rtl/axi4lite_master_mipi.sv
// ---------------------------------------------------------------------------
// axi4lite_master_mipi
//
// AXI4-Lite initiator for a local register sequencer, typically a sensor or
// MIPI configuration engine. Each accepted single-beat command becomes one
// AXI4-Lite write (aw + w, then b) or one read (ar, then r). Only one
// transaction is outstanding at a time. The captured response is then
// presented on the rsp_* port until the sequencer consumes it.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   cmd_*              command in: valid/ready, write flag, addr, wdata, wstrb
//   rsp_*              completion out: valid/ready, read data (0 on writes),
//                      bresp/rresp passed through unmodified
//   aw*/w*/b*          AXI4-Lite write address, write data and write response
//   ar*/r*             AXI4-Lite read address and read data
//
// Every output is registered except awprot/arprot, which are tied to 0.
// There is no timeout, so a slave that never responds stalls the block.
// ---------------------------------------------------------------------------
module axi4lite_master_mipi #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // AXI4-Lite write address
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [2:0]                awprot,
  // AXI4-Lite write data
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  // AXI4-Lite write response
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  // AXI4-Lite read address
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [2:0]                arprot,
  // AXI4-Lite read data
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t state;

  // Write-side handshake tracking. The aw and w channels complete
  // independently, in either order or together.
  logic aw_done;
  logic w_done;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Unprivileged, secure, data access for every transaction.
  assign awprot = 3'b000;
  assign arprot = 3'b000;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is re-asserted every idle cycle. This is what raises it
          // on the first clock after reset release.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end

        WR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // A channel counts as complete if it handshook in an earlier cycle
          // (flag) or handshakes in this one. This covers every ordering.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid && bready) begin
            rsp_resp  <= bresp;
            rsp_rdata <= '0;
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RD_ADDR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid && rready) begin
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RSP: begin
          // The completion is held stable until the sequencer takes it. New
          // commands become acceptable only from the following cycle.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_master_mipi.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_master_mipi
//
// Self-checking bench for axi4lite_master_mipi. A behavioural AXI4-Lite slave
// runs on the falling edge. It has configurable ready waits, response delays
// and response codes, and keeps its own memory. The sequencer side keeps a
// reference register file updated from the commands it issues. Read data and
// response codes are compared against that reference, and the bus traffic is
// checked for correct addresses, data, beat counts and stability.
// ---------------------------------------------------------------------------
module tb_axi4lite_master_mipi;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  axi4lite_master_mipi #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + i * 32'h0000_0101;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Command currently on the bus (used by the slave for address/data checks).
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_strb;

  // Slave behaviour for the next transaction, owned by the sequencer side.
  int          cfg_aw_wait, cfg_w_wait, cfg_ar_wait, cfg_b_dly, cfg_r_dly;
  logic [1:0]  cfg_bresp, cfg_rresp;

  // Reference register file (sequencer's view).
  logic [31:0] ref_mem [16];

  // ---------------- behavioural AXI4-Lite slave ----------------
  logic [31:0] slv_mem [16];
  int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  bit          aw_hs, w_hs, ar_hs, b_hs, r_hs;
  bit          aw_got, w_got, b_pend, r_pend;
  bit          p_aw, p_w, p_ar, p_b, p_r;
  int          awc, wc, arc, bcnt, rcnt;
  logic [31:0] q_awaddr, q_wdata, q_araddr;
  logic [3:0]  q_wstrb;
  logic [3:0]  r_idx;

  initial begin
    for (int i = 0; i < 16; i++) slv_mem[i] = init_word(i);
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;
      end else begin
        // valids/readies pending without a handshake must persist unchanged
        if (p_aw) chk("aw_hold", {awvalid, awaddr}, {1'b1, q_awaddr});
        if (p_w)  chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, q_wdata, q_wstrb});
        if (p_ar) chk("ar_hold", {arvalid, araddr}, {1'b1, q_araddr});
        if (p_b)  chk("bready_hold", bready, 1);
        if (p_r)  chk("rready_hold", rready, 1);
        // effects of handshakes at the previous rising edge
        if (aw_hs) begin awready = 0; aw_got = 1; aw_n++; chk("aw_drop", awvalid, 0); end
        if (w_hs)  begin wready = 0; w_got = 1; w_n++; chk("w_drop", wvalid, 0); end
        if (ar_hs) begin
          arready = 0; ar_n++; r_pend = 1; rcnt = cfg_r_dly; r_idx = q_araddr[5:2];
          chk("ar_drop", arvalid, 0);
        end
        if (b_hs) begin bvalid = 0; b_n++; end
        if (r_hs) begin rvalid = 0; r_n++; end
        if (aw_got && w_got) begin
          slv_mem[q_awaddr[5:2]] = merge(slv_mem[q_awaddr[5:2]], q_wdata, q_wstrb);
          aw_got = 0; w_got = 0; b_pend = 1; bcnt = cfg_b_dly;
        end
        if (b_pend) begin
          if (bcnt == 0) begin bvalid = 1; bresp = cfg_bresp; b_pend = 0; end
          else bcnt--;
        end
        if (r_pend) begin
          if (rcnt == 0) begin rvalid = 1; rdata = slv_mem[r_idx]; rresp = cfg_rresp; r_pend = 0; end
          else rcnt--;
        end
        // ready generation: assert after the configured number of wait cycles
        if (!awvalid) awc = cfg_aw_wait;
        else if (!awready) begin if (awc == 0) awready = 1; else awc--; end
        if (!wvalid) wc = cfg_w_wait;
        else if (!wready) begin if (wc == 0) wready = 1; else wc--; end
        if (!arvalid) arc = cfg_ar_wait;
        else if (!arready) begin if (arc == 0) arready = 1; else arc--; end
        // handshakes that will occur at the next rising edge
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        ar_hs = arvalid && arready;
        b_hs  = bvalid && bready;
        r_hs  = rvalid && rready;
        if (aw_hs) begin chk("awaddr", awaddr, cur_addr); chk("awprot", awprot, 0); end
        if (w_hs)  begin chk("wdata", wdata, cur_data); chk("wstrb", wstrb, cur_strb); end
        if (ar_hs) begin chk("araddr", araddr, cur_addr); chk("arprot", arprot, 0); end
        if (awvalid) q_awaddr = awaddr;
        if (wvalid) begin q_wdata = wdata; q_wstrb = wstrb; end
        if (arvalid) q_araddr = araddr;
        p_aw = awvalid && !aw_hs;
        p_w  = wvalid && !w_hs;
        p_ar = arvalid && !ar_hs;
        p_b  = bready && !b_hs;
        p_r  = rready && !r_hs;
      end
    end
  end

  // ---------------- sequencer-side helpers ----------------
  task automatic check_zero(input string pfx);
    chk({pfx, "_cmd_ready"}, cmd_ready, 0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_rdata"}, rsp_rdata, 0);
    chk({pfx, "_rsp_resp"}, rsp_resp, 0);
    chk({pfx, "_aw"}, {awvalid, awaddr, awprot}, 0);
    chk({pfx, "_w"}, {wvalid, wdata, wstrb}, 0);
    chk({pfx, "_ar"}, {arvalid, araddr, arprot}, 0);
    chk({pfx, "_bready"}, bready, 0);
    chk({pfx, "_rready"}, rready, 0);
  endtask

  task automatic set_slave(input int aww, input int ww, input int arw, input int bd,
                           input int rd, input logic [1:0] br, input logic [1:0] rr);
    cfg_aw_wait = aww; cfg_w_wait = ww; cfg_ar_wait = arw;
    cfg_b_dly = bd; cfg_r_dly = rd; cfg_bresp = br; cfg_rresp = rr;
  endtask

  // Issue one command, hold the response for 'hold' cycles, then consume it.
  // 'lat' is the cycle in which rsp_valid is first seen (acceptance = cycle 0).
  task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, output int lat);
    int n;
    int aw0, w0, b0, ar0, r0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = wr ? 32'h0 : ref_mem[a[5:2]];
    exp_r = wr ? cfg_bresp : cfg_rresp;
    aw0 = aw_n; w0 = w_n; b0 = b_n; ar0 = ar_n; r0 = r_n;
    lat = 0;
    @(negedge aclk);
    cur_addr = a; cur_data = d; cur_strb = s;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
    if (!cmd_ready) begin chk("accept_timeout", 0, 1); cmd_valid = 0; return; end
    @(negedge aclk);
    cmd_valid = 0;
    lat = 1;
    // while busy, random commands on the port must be ignored
    while (!rsp_valid && lat < 200) begin
      chk("busy_cmd_ready", cmd_ready, 0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr = $urandom; cmd_wdata = $urandom;
      @(negedge aclk);
      lat++;
    end
    if (!rsp_valid) begin chk("rsp_timeout", 0, 1); cmd_valid = 0; return; end
    chk(wr ? "wr_rsp_rdata" : "rd_rsp_rdata", rsp_rdata, exp_d);
    chk(wr ? "wr_rsp_resp" : "rd_rsp_resp", rsp_resp, exp_r);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      @(negedge aclk);
      chk("hold_rsp", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, exp_d, exp_r});
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("beats", {8'(aw_n - aw0), 8'(w_n - w0), 8'(b_n - b0), 8'(ar_n - ar0), 8'(r_n - r0)},
        wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
    if (wr) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
  endtask

  // ---------------- main sequence ----------------
  int lat;
  bit wr;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; rsp_ready = 0;
    cur_addr = 0; cur_data = 0; cur_strb = 0;
    set_slave(0, 0, 0, 1, 1, 2'b00, 2'b00);

    // reset values, then cmd_ready rises on the first clock after release
    repeat (3) @(negedge aclk);
    check_zero("rst");
    #1 aresetn = 1;
    #1 chk("rel_cmd_ready0", cmd_ready, 0);
    @(negedge aclk);
    chk("rel_cmd_ready1", cmd_ready, 1);

    // write, zero-wait slave
    set_slave(0, 0, 0, 1, 1, 2'b00, 2'b00);
    do_cmd(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, lat);
    chk("lat_write", lat, 4);

    // read of the written word, zero-wait slave
    do_cmd(0, 32'h0000_0010, 32'h0, 4'h0, 0, lat);
    chk("lat_read", lat, 4);

    // read with rdata 0x12345678 returned 5 cycles late
    do_cmd(1, 32'h0000_0024, 32'h1234_5678, 4'hF, 0, lat);
    set_slave(0, 0, 2, 1, 5, 2'b00, 2'b00);
    do_cmd(0, 32'h0000_0024, 32'h0, 4'h0, 0, lat);
    chk("rd_slow_data_seen", ref_mem[9], 32'h1234_5678);
    chk("lat_read_slow", lat, 10);

    // wready three cycles after awready, partial strobes
    set_slave(0, 3, 0, 1, 1, 2'b00, 2'b00);
    do_cmd(1, 32'h0000_0030, 32'hA1B2_C3D4, 4'b0101, 0, lat);
    chk("lat_w_late", lat, 7);
    set_slave(0, 0, 0, 1, 1, 2'b00, 2'b00);
    do_cmd(0, 32'h0000_0030, 32'h0, 4'h0, 0, lat);

    // response backpressure for 4 cycles
    do_cmd(0, 32'h0000_0024, 32'h0, 4'h0, 4, lat);

    // error responses passed through, block returns to idle
    set_slave(0, 0, 0, 1, 1, 2'b11, 2'b10);
    do_cmd(0, 32'h0000_0004, 32'h0, 4'h0, 1, lat);
    do_cmd(1, 32'h0000_0008, 32'h5555_AAAA, 4'hF, 0, lat);
    set_slave(0, 0, 0, 1, 1, 2'b00, 2'b00);
    do_cmd(0, 32'h0000_0008, 32'h0, 4'h0, 0, lat);

    // reset while wvalid is still pending
    set_slave(0, 20, 0, 1, 1, 2'b00, 2'b00);
    @(negedge aclk);
    cur_addr = 32'h0000_003C; cur_data = 32'hFFFF_FFFF; cur_strb = 4'hF;
    cmd_valid = 1; cmd_write = 1; cmd_addr = cur_addr; cmd_wdata = cur_data; cmd_wstrb = cur_strb;
    @(negedge aclk);
    cmd_valid = 0;
    @(negedge aclk);
    chk("mid_wvalid", {awvalid, wvalid}, 2'b01);
    #1 aresetn = 0;
    #1 check_zero("midrst");
    set_slave(0, 0, 0, 1, 1, 2'b00, 2'b00);
    repeat (2) @(negedge aclk);
    #1 aresetn = 1;
    @(negedge aclk);
    chk("midrst_cmd_ready", cmd_ready, 1);
    do_cmd(0, 32'h0000_003C, 32'h0, 4'h0, 0, lat);
    chk("lat_after_rst", lat, 4);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 4),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      wr = 1'($urandom_range(0, 1));
      do_cmd(wr, {$urandom_range(0, 255), 8'h00, 2'b00, 4'($urandom_range(0, 15)), 2'b00} |
                 {$urandom_range(0, 255), 24'h0},
             $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
